irq_ctrl: RTL
=============

# irq_ctrl

Interrupt controller upstream of the MIPS core wrapper. It synchronizes up to N_SRC asynchronous interrupt sources and latches them as pending. It masks them, selects one by fixed priority, and drives the single-bit request into the core's `interrupter` input. The core acknowledges the request, and firmware retires it with an end-of-interrupt (EOI) write through a small memory-mapped register port.

## Interface
Parameters:
- N_SRC, 4, number of interrupt sources (1..16)
- SYNC_STAGES, 2, synchronizer depth per source (≥2)

Ports:
- clk  in  1  main clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- src  in  N_SRC  raw interrupt sources, asynchronous to clk
- ack  in  1  core accepted the request (1-cycle pulse)
- cfg_we  in  1  register write strobe
- cfg_addr  in  2  register select
- cfg_din  in  32  register write data
- cfg_dout  out  32  register read data (combinational from cfg_addr)
- irq  out  1  request to core `interrupter`
- irq_id  out  4  index of the requesting or in-service source

## Operation
- Each src bit passes through a SYNC_STAGES flop chain to produce `s`. A delayed copy `s_d` gives the rising-edge term `s & ~s_d`.
- pending[i] depends on EDGE[i]:
  - EDGE[i]=0 (level): pending[i] registers s[i] every cycle.
  - EDGE[i]=1 (edge): pending[i] sets on a rising edge and holds until cleared.
- Candidate vector is pending & MASK. The winner is the lowest set index.
- Registers:
  - addr 0, MASK: rw, bits [N_SRC-1:0]; upper bits read 0.
  - addr 1, EDGE: rw, bits [N_SRC-1:0].
  - addr 2, PENDING: read returns pending. Writing 1 clears the bit for edge sources only; writes to level bits are ignored.
  - addr 3, STATUS/EOI: read returns {27'b0, in_service, irq_id}. Any write is an EOI.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If the candidate vector is non-zero, latch the winner into irq_id and go to REQ.
  - irq=0.
- REQ:
  - irq=1; irq_id is stable.
  - ack → SERVICE. On that edge, the edge-type pending bit of irq_id clears.
  - If the candidate bit for irq_id drops before ack (level source released, or mask cleared) → IDLE with irq=0; the request is withdrawn.
  - A higher-priority source arriving in REQ does not preempt.
- SERVICE:
  - irq=0; in_service=1.
  - EOI write → IDLE.
  - New pending bits keep accumulating; they are requested after EOI.
- ack outside REQ is ignored. EOI outside SERVICE is ignored.

## Timing
- All outputs, registers and sync flops reset asynchronously while rst_n=0:
  - irq=0, irq_id=0, state=IDLE, in_service=0.
  - MASK=0, EDGE=0, pending=0, sync chain=0.
- Latency: src is captured by the first sync flop at edge t0 (for an edge source, s_d must hold 0). pending sets at edge t0+SYNC_STAGES, and irq rises at edge t0+SYNC_STAGES+1. With the default SYNC_STAGES=2 this is edge t0+3.
- ack sampled at edge t: irq=0 after t; the pending clear also takes effect at t.
- EOI at edge t: state=IDLE after t. If candidates remain, irq reasserts after edge t+1.
- Same-edge conflicts:
  - Hardware set and W1C on the same bit: set wins.
  - ack and a new edge on the in-service source: the new edge stays pending.
  - MASK write takes effect on the candidate vector the cycle after the write edge.
- rst_n asserted mid-REQ or mid-SERVICE: immediate return to reset values; no pending survives.

## Configuration
- IRQ_EDGE_EN defined:
  - EDGE register implemented; edge detection, sticky pending and W1C are supported as above.
- IRQ_EDGE_EN undefined:
  - EDGE reads 0 and writes are ignored.
  - All sources are level-sensitive; the s_d flops and W1C logic are removed.
  - PENDING reads as the synchronized level.
  - The ack-time pending clear is absent.

## Test plan
- Reset: hold rst_n=0 with src=4'hF → irq=0, irq_id=0, cfg_dout=0 at all addrs. Release; MASK=0 keeps irq=0 indefinitely.
- Latency and priority: MASK=4'hF, EDGE=0, raise src=4'b1100 before edge t0 → irq rises after edge t0+3 with irq_id=2. ack → irq=0, STATUS=0x12. EOI with src still 4'b1100 → irq reasserts after edge t+1 with irq_id=2.
- Edge sticky plus W1C: EDGE=4'h1, pulse src[0] for 3 cycles → PENDING=1 after pulse end. Write 1 to addr 2 → PENDING=0; no irq if MASK is set only after the clear.
- Withdraw: level src[1] high, MASK=2, irq=1; drop src[1] before ack → irq falls SYNC_STAGES+1 edges after src drop, state IDLE, late ack ignored.
- Conflict: edge source in REQ; ack on the same edge as a new src[0] rising edge → SERVICE, PENDING[0]=1. EOI → irq=1, irq_id=0.
- Async reset mid-SERVICE: pulse rst_n low for half a cycle → irq=0, STATUS=0, MASK=0 immediately without a clk edge.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Register/request bus between irq_ctrl and its host (core + firmware port).
// master: host side (drives cfg writes and ack); slave: irq_ctrl.
interface irq_ctrl_if;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_din;
   logic [31:0] cfg_dout;
   logic        ack;
   logic        irq;
   logic [3:0]  irq_id;

   modport master (
      output cfg_we, cfg_addr, cfg_din, ack,
      input  cfg_dout, irq, irq_id
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_din, ack,
      output cfg_dout, irq, irq_id
   );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronizes N_SRC async interrupt sources, latches them as pending,
// masks them, picks the lowest-index candidate and requests the core.
// Optional feature macro: IRQ_EDGE_EN (EDGE register, sticky edge pending, W1C,
// ack-time clear). Without it every source is level-sensitive.
//
// state   | meaning
// IDLE    | no request outstanding; waiting for a masked pending source
// REQ     | irq=1 for irq_id; waiting for ack or withdrawal
// SERVICE | core is servicing irq_id; waiting for EOI write
module irq_ctrl #(
   parameter int N_SRC       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] src,
   irq_ctrl_if.slave        bus
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t                             state;
   logic [SYNC_STAGES-1:0][N_SRC-1:0]  sync_q;
   logic [N_SRC-1:0]                   s;
   logic [N_SRC-1:0]                   mask_q;
   logic [N_SRC-1:0]                   edge_sel;
   logic [N_SRC-1:0]                   pending;
   logic [N_SRC-1:0]                   pend_nxt;
   logic [N_SRC-1:0]                   cand;
   logic [N_SRC-1:0]                   id_bit;
   logic [3:0]                         win_id;
   logic                               win_vld;
   logic                               irq_q;
   logic [3:0]                         irq_id_q;
   logic                               in_service;
   logic [31:0]                        rdata;
   logic                               we_mask;
   logic                               eoi;
   logic                               unused_din;

   assign s       = sync_q[SYNC_STAGES-1];
   assign cand    = pending & mask_q;
   assign we_mask = bus.cfg_we && (bus.cfg_addr == 2'd0);
   assign eoi     = bus.cfg_we && (bus.cfg_addr == 2'd3);
   // only the low N_SRC data bits carry register content
   assign unused_din = &{1'b0, bus.cfg_din};

   // metastability chain, newest sample in stage 0
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], src};

   // mask register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)       mask_q <= '0;
      else if (we_mask) mask_q <= bus.cfg_din[N_SRC-1:0];

   // one-hot of the latched request id
   always_comb begin
      id_bit = '0;
      for (int i = 0; i < N_SRC; i++) id_bit[i] = (irq_id_q == 4'(i));
   end

`ifdef IRQ_EDGE_EN
   logic [N_SRC-1:0] s_d;
   logic [N_SRC-1:0] edge_q;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] clr;

   // delayed synchronized level for rising-edge detection
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) s_d <= '0;
      else        s_d <= s;

   // edge-select register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                                    edge_q <= '0;
      else if (bus.cfg_we && bus.cfg_addr == 2'd1)   edge_q <= bus.cfg_din[N_SRC-1:0];

   // W1C and ack clears only touch edge sources; a same-edge set still wins
   always_comb begin
      rise = s & ~s_d;
      clr  = '0;
      if (bus.cfg_we && bus.cfg_addr == 2'd2) clr = clr | bus.cfg_din[N_SRC-1:0];
      if (state == REQ && bus.ack)            clr = clr | id_bit;
      clr      = clr & edge_q;
      pend_nxt = (edge_q & ((pending & ~clr) | rise)) | (~edge_q & s);
   end

   assign edge_sel = edge_q;
`else
   assign pend_nxt = s;
   assign edge_sel = '0;
`endif

   // pending latch
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pending <= '0;
      else        pending <= pend_nxt;

   // fixed priority: lowest set index wins
   always_comb begin
      win_vld = 1'b0;
      win_id  = 4'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (cand[i]) begin
            win_vld = 1'b1;
            win_id  = 4'(i);
         end
      end
   end

   // request FSM with registered outputs; ack takes precedence over withdrawal
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         irq_q      <= 1'b0;
         irq_id_q   <= 4'd0;
         in_service <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (win_vld) begin
                  state    <= REQ;
                  irq_q    <= 1'b1;
                  irq_id_q <= win_id;
               end
            REQ:
               if (bus.ack) begin
                  state      <= SERVICE;
                  irq_q      <= 1'b0;
                  in_service <= 1'b1;
               end else if ((cand & id_bit) == '0) begin
                  state <= IDLE;
                  irq_q <= 1'b0;
               end
            SERVICE:
               if (eoi) begin
                  state      <= IDLE;
                  in_service <= 1'b0;
               end
            default: begin
               state      <= IDLE;
               irq_q      <= 1'b0;
               in_service <= 1'b0;
            end
         endcase
      end

   // register read mux
   always_comb begin
      rdata = '0;
      case (bus.cfg_addr)
         2'd0:    rdata[N_SRC-1:0] = mask_q;
         2'd1:    rdata[N_SRC-1:0] = edge_sel;
         2'd2:    rdata[N_SRC-1:0] = pending;
         default: rdata[4:0]       = {in_service, irq_id_q};
      endcase
   end

   assign bus.cfg_dout = rdata;
   assign bus.irq      = irq_q;
   assign bus.irq_id   = irq_id_q;
endmodule
